mem_resp2: RTL and testbench
============================

// Module: mem_resp2
// PURPOSE
//  Shared main-memory responder at the memory end of the cache<->memory request interface.
//  Serves two MSI snooping cache controllers (port 0, port 1): accepts single-cycle RD/WT
//  request pulses, arbitrates round-robin, waits a fixed access latency, then answers with a
//  one-cycle readEn / writeDone pulse. Sits between the two cache instances and the top level.
// PARAMETERS
//  DEPTH    16  number of WORDWIDTH-bit words; valid addresses 0..DEPTH-1
//  LATENCY  2   array access cycles between grant and response (legal range 1..15)
// PORTS
//  clk              in   1              single clock; all state changes on posedge
//  reset            in   1              asynchronous, active-low reset
//  rwFromCache0     in   IOSTATEWIDTH   port-0 request: IDEL / RD / WT, one-cycle pulse
//  addrFromCache0   in   ADDRWIDTH      port-0 address, valid with the request pulse
//  dataFromCache0   in   WORDWIDTH      port-0 write data, valid with a WT pulse
//  readEnToCache0   out  1              port-0 read-complete pulse
//  writeDoneToCache0 out 1              port-0 write-complete pulse
//  dataToCache0     out  WORDWIDTH      port-0 read data, valid with readEnToCache0
//  rwFromCache1 .. dataToCache1         port 1, identical to port 0
//  errToCache       out  1              sticky range error (only with MEMRESP_ADDR_CHECK_EN)
// BEHAVIOUR
//  Reset (reset==0, async): all outputs 0, pending[1:0]=0, state IDLE, rrPtr=0 (port 0 first),
//   counter 0, array cleared to 0. Reset mid-access abandons it; no response is issued.
//  Capture: at each edge, a port with rw!=IDEL and pending==0 latches {rw,addr,data} and sets
//   pending. A request while pending or in service is dropped (protocol violation).
//  FSM IDLE->BUSY->RESP->IDLE:
//   IDLE: if any pending, grant (both pending: port != rrPtr... i.e. rrPtr wins, then rrPtr
//    toggles to the other port); load counter=LATENCY-1; ->BUSY. Otherwise stay.
//   BUSY: counter decrements; at 0 ->RESP, performing the access on that edge:
//    RD: dataToCacheN<=mem[addr]; readEnToCacheN<=1. WT: mem[addr]<=data; writeDoneToCacheN<=1.
//    The granted pending bit clears on the same edge.
//   RESP: the response pulse is high exactly this one cycle; ->IDLE, pulses return to 0.
//  Latency: uncontended request at edge E0 -> pulse high in the cycle after edge E0+LATENCY+1.
//  dataToCacheN holds its value until that port's next read response.
//  Ordering: accesses are serialised in grant order; a read granted after a write to the same
//   address returns the new data. Same-cycle requests from both ports: rrPtr port served first,
//   other port served immediately after (back-to-back, one IDLE cycle between).
//  A request captured in the RESP cycle or later waits in pending; none is ever lost.
//  Addressing: index = addr modulo DEPTH (low log2(DEPTH) bits) unless check enabled.
// CONFIGURATION
//  MEMRESP_ADDR_CHECK_EN defined: addr>=DEPTH is still granted and timed normally, but RD
//   returns 0, WT does not modify the array, and errToCache sets (cleared only by reset).
//  Undefined: no check, address wraps modulo DEPTH, errToCache tied 0.
// STRUCTURE
//  def.v (shared): IDEL/RD/WT codes, ADDRWIDTH, WORDWIDTH, IOSTATEWIDTH, plus new
//   MR_IDLE/MR_BUSY/MR_RESP encodings and MR_STATEWIDTH.
//  One sub-module: rr_arb2 (2 requesters, pointer register, grant + valid outputs).
//  Request capture registers, counter, FSM and array live in mem_resp2.
// TESTING
//  1 Reset low with requests driven -> all outputs 0, no pulse for 10 cycles after release.
//  2 P0 WT addr 3 data 0xA5 at E0 -> writeDone0 single pulse in cycle after E3 (LATENCY=2);
//    then P0 RD addr 3 -> readEn0 pulse with dataToCache0=0xA5.
//  3 P0 WT addr 5 =0x11 and P1 RD addr 5 same edge -> P0 served first, P1 reads 0x11;
//    next simultaneous pair -> P1 served first (round-robin).
//  4 P1 RD while P1 pending -> second request dropped, exactly one readEn1 pulse.
//  5 Assert reset during BUSY -> no pulse, array reads 0 after release.
//  6 With MEMRESP_ADDR_CHECK_EN: RD addr DEPTH -> readEn pulse, data 0, errToCache=1 sticky;
//    without: WT addr DEPTH+2 then RD addr 2 returns written data.

Source files
------------

// File: rtl/mem_resp2_pkg.sv
// Shared definitions for the two-port memory responder: request codes,
// bus widths and the responder FSM encodings.
package mem_resp2_pkg;

  // Request interface widths
  localparam int IOSTATEWIDTH = 2;
  localparam int ADDRWIDTH    = 8;
  localparam int WORDWIDTH    = 8;

  // Request codes driven by the cache controllers
  localparam logic [IOSTATEWIDTH-1:0] IDEL = 2'd0;
  localparam logic [IOSTATEWIDTH-1:0] RD   = 2'd1;
  localparam logic [IOSTATEWIDTH-1:0] WT   = 2'd2;

  // Responder FSM encodings
  localparam int MR_STATEWIDTH = 2;
  typedef enum logic [MR_STATEWIDTH-1:0] {
    MR_IDLE = 2'd0,
    MR_BUSY = 2'd1,
    MR_RESP = 2'd2
  } mr_state_t;

  // Only the two defined operation codes start a transaction; the unused
  // encoding is treated like IDEL so it can never reach the array.
  function automatic logic is_req(input logic [IOSTATEWIDTH-1:0] rw);
    return (rw == RD) || (rw == WT);
  endfunction

endpackage

// File: rtl/mem_resp2_rr_arb2.sv
// Two-requester round-robin arbiter. The pointer names the port that wins
// when both request together; it flips only after such a contended grant,
// so a lone requester never steals the other port's turn.
module mem_resp2_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic       grant,
  output logic       valid
);

  logic ptr;

  assign valid = |req;

  // Grant selection: pointer breaks ties, otherwise the single requester wins
  always_comb begin
    grant = req[1];
    if (req == 2'b11) grant = ptr;
  end

  // Pointer moves to the losing port after a contended grant is taken
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= 1'b0;
    end else if (take && (req == 2'b11)) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/mem_resp2.sv
// Shared main-memory responder for two snooping cache controllers.
// Captures one outstanding request per port, serialises them round-robin,
// waits LATENCY cycles and answers with a one-cycle readEn/writeDone pulse.
// Optional feature: define MEMRESP_ADDR_CHECK_EN to flag out-of-range
// addresses (sticky errToCache) instead of wrapping them modulo DEPTH.
module mem_resp2
  import mem_resp2_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IOSTATEWIDTH-1:0] rwFromCache0,
  input  logic [ADDRWIDTH-1:0]    addrFromCache0,
  input  logic [WORDWIDTH-1:0]    dataFromCache0,
  output logic                    readEnToCache0,
  output logic                    writeDoneToCache0,
  output logic [WORDWIDTH-1:0]    dataToCache0,
  input  logic [IOSTATEWIDTH-1:0] rwFromCache1,
  input  logic [ADDRWIDTH-1:0]    addrFromCache1,
  input  logic [WORDWIDTH-1:0]    dataFromCache1,
  output logic                    readEnToCache1,
  output logic                    writeDoneToCache1,
  output logic [WORDWIDTH-1:0]    dataToCache1,
  output logic                    errToCache
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = 4;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(LATENCY - 1);

  // Per-port views of the request inputs
  logic [IOSTATEWIDTH-1:0] rw_in   [2];
  logic [ADDRWIDTH-1:0]    addr_in [2];
  logic [WORDWIDTH-1:0]    data_in [2];

  assign rw_in[0]   = rwFromCache0;
  assign addr_in[0] = addrFromCache0;
  assign data_in[0] = dataFromCache0;
  assign rw_in[1]   = rwFromCache1;
  assign addr_in[1] = addrFromCache1;
  assign data_in[1] = dataFromCache1;

  // Captured requests
  logic [1:0]              pending;
  logic [IOSTATEWIDTH-1:0] req_rw   [2];
  logic [ADDRWIDTH-1:0]    req_addr [2];
  logic [WORDWIDTH-1:0]    req_data [2];

  // Service state
  mr_state_t             state;
  logic [CNTW-1:0]       cnt;
  logic                  svc;
  logic [WORDWIDTH-1:0]  mem [DEPTH];

  logic                  arb_grant;
  logic                  arb_valid;
  logic                  access;
  logic [1:0]            done;
  logic [IOSTATEWIDTH-1:0] svc_rw;
  logic [ADDRWIDTH-1:0]  svc_addr;
  logic [WORDWIDTH-1:0]  svc_data;
  logic [IDXW-1:0]       svc_idx;
  logic                  in_range;
  logic [WORDWIDTH-1:0]  rd_word;

  mem_resp2_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (pending),
    .take  (state == MR_IDLE),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  // The array access happens on the edge that leaves BUSY
  assign access   = (state == MR_BUSY) && (cnt == '0);
  assign done     = access ? (svc ? 2'b10 : 2'b01) : 2'b00;
  assign svc_rw   = req_rw[svc];
  assign svc_addr = req_addr[svc];
  assign svc_data = req_data[svc];
  assign svc_idx  = svc_addr[IDXW-1:0];

`ifdef MEMRESP_ADDR_CHECK_EN
  localparam logic [ADDRWIDTH:0] DEPTH_W = (ADDRWIDTH+1)'(DEPTH);
  assign in_range = ({1'b0, svc_addr} < DEPTH_W);
`else
  logic unused_addr_hi;
  assign in_range       = 1'b1;
  assign unused_addr_hi = ^svc_addr[ADDRWIDTH-1:IDXW];
  assign errToCache     = 1'b0;
`endif

  assign rd_word = in_range ? mem[svc_idx] : '0;

  // Request capture: one slot per port; requests arriving while the slot is busy are dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        req_rw[i]   <= IDEL;
        req_addr[i] <= '0;
        req_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!pending[i] && is_req(rw_in[i])) begin
          pending[i]  <= 1'b1;
          req_rw[i]   <= rw_in[i];
          req_addr[i] <= addr_in[i];
          req_data[i] <= data_in[i];
        end else if (done[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // Responder FSM with registered response pulses, read data and array
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= MR_IDLE;
      cnt               <= '0;
      svc               <= 1'b0;
      readEnToCache0    <= 1'b0;
      writeDoneToCache0 <= 1'b0;
      dataToCache0      <= '0;
      readEnToCache1    <= 1'b0;
      writeDoneToCache1 <= 1'b0;
      dataToCache1      <= '0;
`ifdef MEMRESP_ADDR_CHECK_EN
      errToCache        <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      readEnToCache0    <= 1'b0;
      writeDoneToCache0 <= 1'b0;
      readEnToCache1    <= 1'b0;
      writeDoneToCache1 <= 1'b0;
      case (state)
        MR_IDLE: begin
          if (arb_valid) begin
            svc   <= arb_grant;
            cnt   <= CNT_LOAD;
            state <= MR_BUSY;
          end
        end
        MR_BUSY: begin
          if (cnt == '0) begin
            state <= MR_RESP;
            if (svc_rw == RD) begin
              if (svc) begin
                dataToCache1   <= rd_word;
                readEnToCache1 <= 1'b1;
              end else begin
                dataToCache0   <= rd_word;
                readEnToCache0 <= 1'b1;
              end
            end else begin
              if (in_range) mem[svc_idx] <= svc_data;
              if (svc) writeDoneToCache1 <= 1'b1;
              else     writeDoneToCache0 <= 1'b1;
            end
`ifdef MEMRESP_ADDR_CHECK_EN
            if (!in_range) errToCache <= 1'b1;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MR_RESP: state <= MR_IDLE;
        default: state <= MR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_resp2.sv
// Directed self-checking bench for mem_resp2 (DEPTH=16, LATENCY=2).
module tb_mem_resp2;
  import mem_resp2_pkg::*;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic [IOSTATEWIDTH-1:0] rw0 = IDEL, rw1 = IDEL;
  logic [ADDRWIDTH-1:0]    addr0 = '0, addr1 = '0;
  logic [WORDWIDTH-1:0]    din0 = '0, din1 = '0;
  logic                    re0, wd0, re1, wd1, err;
  logic [WORDWIDTH-1:0]    dout0, dout1;

  int errors = 0;
  int checks = 0;

  // Per-port pulse observations collected by run()
  int          rd_cnt [2];
  int          wr_cnt [2];
  int          rd_at  [2];
  int          wr_at  [2];
  logic [7:0]  rd_dat [2];

  mem_resp2 #(.DEPTH(16), .LATENCY(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .rwFromCache0      (rw0),
    .addrFromCache0    (addr0),
    .dataFromCache0    (din0),
    .readEnToCache0    (re0),
    .writeDoneToCache0 (wd0),
    .dataToCache0      (dout0),
    .rwFromCache1      (rw1),
    .addrFromCache1    (addr1),
    .dataFromCache1    (din1),
    .readEnToCache1    (re1),
    .writeDoneToCache1 (wd1),
    .dataToCache1      (dout1),
    .errToCache        (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic [1:0] rw, input logic [7:0] a, input logic [7:0] d);
    if (p == 0) begin
      rw0 = rw; addr0 = a; din0 = d;
    end else begin
      rw1 = rw; addr1 = a; din1 = d;
    end
  endtask

  // Present a one-cycle request pulse on one port
  task automatic req(input int p, input logic [1:0] rw, input logic [7:0] a, input logic [7:0] d);
    $display("req port%0d rw=%0d addr=0x%0h data=0x%0h", p, rw, a, d);
    drive(p, rw, a, d);
    tick();
    drive(p, IDEL, 8'h00, 8'h00);
  endtask

  // Present requests on both ports in the same cycle
  task automatic req2(input logic [1:0] r0, input logic [7:0] a0, input logic [7:0] d0,
                      input logic [1:0] r1, input logic [7:0] a1, input logic [7:0] d1);
    $display("req port0 rw=%0d addr=0x%0h data=0x%0h + port1 rw=%0d addr=0x%0h data=0x%0h",
             r0, a0, d0, r1, a1, d1);
    drive(0, r0, a0, d0);
    drive(1, r1, a1, d1);
    tick();
    drive(0, IDEL, 8'h00, 8'h00);
    drive(1, IDEL, 8'h00, 8'h00);
  endtask

  // Watch n cycles, recording pulse counts, the cycle of the last pulse and read data
  task automatic run(input int n);
    for (int p = 0; p < 2; p++) begin
      rd_cnt[p] = 0; wr_cnt[p] = 0; rd_at[p] = 0; wr_at[p] = 0; rd_dat[p] = 8'hxx;
    end
    for (int k = 1; k <= n; k++) begin
      tick();
      if (re0 === 1'b1) begin rd_cnt[0]++; rd_at[0] = k; rd_dat[0] = dout0; end
      if (wd0 === 1'b1) begin wr_cnt[0]++; wr_at[0] = k; end
      if (re1 === 1'b1) begin rd_cnt[1]++; rd_at[1] = k; rd_dat[1] = dout1; end
      if (wd1 === 1'b1) begin wr_cnt[1]++; wr_at[1] = k; end
    end
  endtask

  initial begin
    // 1: reset held with requests driven
    drive(0, RD, 8'h03, 8'h00);
    drive(1, WT, 8'h04, 8'h99);
    tick(); tick(); tick();
    chk("rst_re0", re0, 1'b0);
    chk("rst_wd0", wd0, 1'b0);
    chk("rst_dout0", dout0, 8'h00);
    chk("rst_re1", re1, 1'b0);
    chk("rst_wd1", wd1, 1'b0);
    chk("rst_dout1", dout1, 8'h00);
    chk("rst_err", err, 1'b0);
    drive(0, IDEL, 8'h00, 8'h00);
    drive(1, IDEL, 8'h00, 8'h00);
    reset = 1'b1;
    run(10);
    chk("post_rst_pulses", rd_cnt[0] + wr_cnt[0] + rd_cnt[1] + wr_cnt[1], 0);

    // 2: uncontended write then read back, checking latency
    req(0, WT, 8'h03, 8'hA5);
    run(6);
    chk("wr0_count", wr_cnt[0], 1);
    chk("wr0_latency", wr_at[0], 3);
    req(0, RD, 8'h03, 8'h00);
    run(6);
    chk("rd0_count", rd_cnt[0], 1);
    chk("rd0_latency", rd_at[0], 3);
    chk("rd0_data", rd_dat[0], 8'hA5);
    chk("rd0_hold", dout0, 8'hA5);

    // 3: simultaneous requests, round-robin order
    req2(WT, 8'h05, 8'h11, RD, 8'h05, 8'h00);
    run(12);
    chk("pair1_wr0_at", wr_at[0], 3);
    chk("pair1_rd1_at", rd_at[1], 7);
    chk("pair1_rd1_data", rd_dat[1], 8'h11);
    req2(RD, 8'h05, 8'h00, WT, 8'h05, 8'h22);
    run(12);
    chk("pair2_wr1_at", wr_at[1], 3);
    chk("pair2_rd0_at", rd_at[0], 7);
    chk("pair2_rd0_data", rd_dat[0], 8'h22);

    // 4: request while pending is dropped
    req(1, RD, 8'h03, 8'h00);
    req(1, RD, 8'h05, 8'h00);
    run(10);
    chk("drop_rd1_count", rd_cnt[1], 1);
    chk("drop_rd1_at", rd_at[1], 2);
    chk("drop_rd1_data", rd_dat[1], 8'hA5);

    // 4b: request captured in the RESP cycle is served back-to-back
    req(0, WT, 8'h09, 8'h3C);
    run(3);
    chk("resp_wr0_at", wr_at[0], 3);
    req(0, RD, 8'h09, 8'h00);
    run(8);
    chk("resp_rd0_count", rd_cnt[0], 1);
    chk("resp_rd0_at", rd_at[0], 3);
    chk("resp_rd0_data", rd_dat[0], 8'h3C);

    // 5: reset during BUSY abandons the access and clears the array
    req(0, WT, 8'h07, 8'h5A);
    tick();
    reset = 1'b0;
    tick();
    chk("busy_rst_dout0", dout0, 8'h00);
    reset = 1'b1;
    run(6);
    chk("busy_rst_pulses", rd_cnt[0] + wr_cnt[0] + rd_cnt[1] + wr_cnt[1], 0);
    req(0, RD, 8'h03, 8'h00);
    run(6);
    chk("cleared_rd3_count", rd_cnt[0], 1);
    chk("cleared_rd3_data", rd_dat[0], 8'h00);
    req(1, RD, 8'h07, 8'h00);
    run(6);
    chk("cleared_rd7_data", rd_dat[1], 8'h00);

    // 6: out-of-range addressing
    req(0, WT, 8'h02, 8'h33);
    run(6);
    req(0, RD, 8'h10, 8'h00);
    run(6);
    chk("oor_rd_count", rd_cnt[0], 1);
    chk("oor_rd_data", rd_dat[0], 8'h00);
    req(1, WT, 8'h12, 8'h77);
    run(6);
    chk("oor_wr_count", wr_cnt[1], 1);
    req(0, RD, 8'h02, 8'h00);
    run(6);
`ifdef MEMRESP_ADDR_CHECK_EN
    chk("oor_rd2_data", rd_dat[0], 8'h33);
    chk("oor_err_sticky", err, 1'b1);
`else
    chk("wrap_rd2_data", rd_dat[0], 8'h77);
    chk("wrap_err_zero", err, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
